// File: rtl/wave_meas.sv
`default_nettype none
// wave_meas: per-cycle period and amplitude measurement of an offset-binary sample stream
// using a Schmitt-trigger crossing detector. Revision 1.0.
module wave_meas #(
    parameter int DATA_W = 14,
    parameter int MID    = 8192,
    parameter int HYST   = 64,
    parameter int CNT_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] ADC_out,
    output logic [CNT_W-1:0]  period,
    output logic [DATA_W-1:0] vmax,
    output logic [DATA_W-1:0] vmin,
    output logic [DATA_W-1:0] vpp,
    output logic              meas_valid,
    output logic              timeout
);

    localparam logic [DATA_W-1:0] HI_TH   = DATA_W'(MID + HYST);
    localparam logic [DATA_W-1:0] LO_TH   = DATA_W'(MID - HYST);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARM_LOW   = 3'd1,
        ARM_HIGH  = 3'd2,
        MEAS_HIGH = 3'd3,
        MEAS_LOW  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [DATA_W-1:0] wmax, wmax_nxt;
    logic [DATA_W-1:0] wmin, wmin_nxt;
    logic              publish;
    logic              to_set;
    logic              accept;
    logic              is_hi;
    logic              is_lo;
    logic [DATA_W-1:0] max_upd;
    logic [DATA_W-1:0] min_upd;

    assign accept  = en & sample_valid;
    assign is_hi   = (ADC_out >= HI_TH);
    assign is_lo   = (ADC_out <= LO_TH);
    assign max_upd = (ADC_out > wmax) ? ADC_out : wmax;
    assign min_upd = (ADC_out < wmin) ? ADC_out : wmin;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        wmax_nxt  = wmax;
        wmin_nxt  = wmin;
        publish   = 1'b0;
        to_set    = 1'b0;
        if (!en) begin
            state_nxt = IDLE;
            count_nxt = '0;
        end else begin
            case (state)
                IDLE: state_nxt = ARM_LOW;
                ARM_LOW: begin
                    if (accept && is_lo) state_nxt = ARM_HIGH;
                end
                ARM_HIGH: begin
                    if (accept && is_hi) begin
                        count_nxt = CNT_ONE;
                        wmax_nxt  = ADC_out;
                        wmin_nxt  = ADC_out;
                        state_nxt = MEAS_HIGH;
                    end
                end
                MEAS_HIGH: begin
                    if (accept) begin
                        if (count == CNT_MAX) begin
                            to_set    = 1'b1;
                            state_nxt = ARM_LOW;
                        end else begin
                            count_nxt = count + CNT_ONE;
                            wmax_nxt  = max_upd;
                            wmin_nxt  = min_upd;
                            if (is_lo) state_nxt = MEAS_LOW;
                        end
                    end
                end
                MEAS_LOW: begin
                    if (accept) begin
                        if (is_hi) begin
                            // Closing edge doubles as the opening edge of the next window
                            publish   = 1'b1;
                            count_nxt = CNT_ONE;
                            wmax_nxt  = ADC_out;
                            wmin_nxt  = ADC_out;
                            state_nxt = MEAS_HIGH;
                        end else if (count == CNT_MAX) begin
                            to_set    = 1'b1;
                            state_nxt = ARM_LOW;
                        end else begin
                            count_nxt = count + CNT_ONE;
                            wmax_nxt  = max_upd;
                            wmin_nxt  = min_upd;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            wmax       <= '0;
            wmin       <= '0;
            period     <= '0;
            vmax       <= '0;
            vmin       <= '0;
            vpp        <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nxt;
            count      <= count_nxt;
            wmax       <= wmax_nxt;
            wmin       <= wmin_nxt;
            meas_valid <= publish;
            if (publish) begin
                period  <= count;
                vmax    <= wmax;
                vmin    <= wmin;
                vpp     <= wmax - wmin;
                timeout <= 1'b0;
            end else if (to_set) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wave_meas.sv
`default_nettype none
// tb_wave_meas: directed, table-driven checks of wave_meas with an 8-bit period counter.
// Revision 1.0.
module tb_wave_meas;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        sample_valid;
    logic [13:0] ADC_out;
    logic [7:0]  period;
    logic [13:0] vmax;
    logic [13:0] vmin;
    logic [13:0] vpp;
    logic        meas_valid;
    logic        timeout;

    wave_meas #(.DATA_W(14), .MID(8192), .HYST(64), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .sample_valid (sample_valid),
        .ADC_out      (ADC_out),
        .period       (period),
        .vmax         (vmax),
        .vmin         (vmin),
        .vpp          (vpp),
        .meas_valid   (meas_valid),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    int pulses = 0;
    int last_t = 0;
    int prev_t = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (meas_valid === 1'b1) begin
            pulses = pulses + 1;
            prev_t = last_t;
            last_t = cyc;
        end
    end

    int total = 0;
    int bad   = 0;
    int base  = 0;

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        sample_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    // One accepted sample, followed by every-1 clocks with sample_valid low
    task automatic put(input int v, input int every);
        ADC_out      = 14'(v);
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        for (int i = 1; i < every; i++) step();
    endtask

    task automatic putn(input int v, input int n, input int every);
        for (int i = 0; i < n; i++) put(v, every);
    endtask

    task automatic rearm();
        sample_valid = 1'b0;
        en = 1'b0;
        step();
        en = 1'b1;
        step();
        base = pulses;
    endtask

    task automatic check_out(input string tag, input int p, input int mx, input int mn, input int pp);
        check({tag, ".period"}, int'(period), p);
        check({tag, ".vmax"},   int'(vmax),   mx);
        check({tag, ".vmin"},   int'(vmin),   mn);
        check({tag, ".vpp"},    int'(vpp),    pp);
    endtask

    function automatic int noise_val(input int i);
        int k;
        k = i % 128;
        if (k <= 61)       return 12000;
        else if (k == 62)  return 8242;
        else if (k == 63)  return 8142;
        else if (k == 64)  return 8242;
        else if (k <= 125) return 4000;
        else if (k == 126) return 8142;
        else               return 8242;
    endfunction

    typedef struct {
        int hi, lo, nhi, nlo, every, ncyc;
        int exp_pulses, exp_period, exp_vmax, exp_vmin, exp_vpp, exp_space;
    } vec_t;

    vec_t tbl[5];

    initial begin
        tbl[0] = '{12000, 4000, 64, 64, 1, 3,  3, 128, 12000, 4000, 8000, 128};
        tbl[1] = '{12000, 4000, 64, 64, 2, 2,  2, 128, 12000, 4000, 8000, 256};
        tbl[2] = '{ 8256, 8128, 10,  5, 1, 3,  3,  15,  8256, 8128,  128,  15};
        tbl[3] = '{16383,    0,  1,  1, 1, 3,  3,   2, 16383,    0, 16383,  2};
        tbl[4] = '{ 8255, 8129, 10,  5, 1, 3,  0,   2, 16383,    0, 16383, -1};

        rst_n = 1'b0;
        en = 1'b0;
        sample_valid = 1'b0;
        ADC_out = '0;
        idle(3);
        check_out("reset", 0, 0, 0, 0);
        check("reset.meas_valid", int'(meas_valid), 0);
        check("reset.timeout", int'(timeout), 0);
        rst_n = 1'b1;
        step();

        for (int t = 0; t < 5; t++) begin
            rearm();
            putn(tbl[t].lo, tbl[t].nlo, tbl[t].every);
            for (int c = 0; c < tbl[t].ncyc; c++) begin
                putn(tbl[t].hi, tbl[t].nhi, tbl[t].every);
                putn(tbl[t].lo, tbl[t].nlo, tbl[t].every);
            end
            put(tbl[t].hi, tbl[t].every);
            idle(3);
            check($sformatf("vec%0d.pulses", t), pulses - base, tbl[t].exp_pulses);
            check_out($sformatf("vec%0d", t), tbl[t].exp_period, tbl[t].exp_vmax,
                      tbl[t].exp_vmin, tbl[t].exp_vpp);
            if (tbl[t].exp_space >= 0)
                check($sformatf("vec%0d.spacing", t), last_t - prev_t, tbl[t].exp_space);
        end

        // Dithered crossings inside the hysteresis band
        rearm();
        putn(4000, 10, 1);
        for (int i = 0; i < 4 * 128; i++) put(noise_val(i), 1);
        put(12000, 1);
        idle(3);
        check("noise.pulses", pulses - base, 4);
        check_out("noise", 128, 12000, 4000, 8000);

        // Timeout: rising edge then held high
        rearm();
        putn(4000, 5, 1);
        putn(12000, 255, 1);
        check("tmo.before", int'(timeout), 0);
        put(12000, 1);
        idle(2);
        check("tmo.set", int'(timeout), 1);
        check("tmo.pulses", pulses - base, 0);
        check_out("tmo.hold", 128, 12000, 4000, 8000);
        putn(12000, 10, 1);
        putn(4000, 64, 1);
        check("tmo.sticky", int'(timeout), 1);
        putn(12000, 64, 1);
        putn(4000, 64, 1);
        put(12000, 1);
        idle(3);
        check("tmo.recover.pulses", pulses - base, 1);
        check("tmo.clear", int'(timeout), 0);
        check("tmo.recover.period", int'(period), 128);

        // Wave that starts high
        rearm();
        putn(11000, 64, 1);
        putn(5000, 64, 1);
        putn(11000, 64, 1);
        idle(2);
        check("starthi.early", pulses - base, 0);
        putn(5000, 64, 1);
        put(11000, 1);
        idle(3);
        check("starthi.pulses", pulses - base, 1);
        check_out("starthi", 128, 11000, 5000, 6000);

        // Asynchronous reset mid-window
        putn(11000, 10, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("midrst", 0, 0, 0, 0);
        check("midrst.timeout", int'(timeout), 0);
        check("midrst.meas_valid", int'(meas_valid), 0);
        step();
        rst_n = 1'b1;
        step();

        // en dropped mid-window, then full re-arm required
        rearm();
        putn(4000, 64, 1);
        putn(12000, 64, 1);
        putn(4000, 64, 1);
        put(12000, 1);
        putn(12000, 20, 1);
        putn(4000, 10, 1);
        en = 1'b0;
        ADC_out = 14'd12000;
        sample_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        sample_valid = 1'b0;
        step();
        check("endis.pulses", pulses - base, 1);
        check_out("endis.hold", 128, 12000, 4000, 8000);
        en = 1'b1;
        step();
        putn(12000, 30, 1);
        putn(4000, 30, 1);
        putn(12000, 50, 1);
        putn(4000, 50, 1);
        put(12000, 1);
        idle(3);
        check("reen.pulses", pulses - base, 2);
        check_out("reen", 100, 12000, 4000, 8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wave_meas.md
Name: wave_meas

Overview:
Capture-side counterpart to the waveform generators. It consumes 14-bit offset-binary samples, as produced for the DAC, from the ADC path or a loopback tap. Per waveform cycle it measures the period in samples and the max, min and peak-to-peak amplitude, and publishes the results with a one-cycle valid strobe. Control logic uses the results for loopback self-test and closed-loop amplitude and frequency checks.

Parameters:
DATA_W, 14, sample width (offset binary; midscale = 2^(DATA_W-1))
MID, 8192, crossing threshold centre
HYST, 64, Schmitt hysteresis half-width in LSBs
CNT_W, 24, period counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
en  in  1  measurement enable
sample_valid  in  1  qualifies ADC_out for this clock
ADC_out  in  DATA_W  input sample, offset binary
period  out  CNT_W  samples per waveform cycle, last result
vmax  out  DATA_W  maximum sample in last cycle
vmin  out  DATA_W  minimum sample in last cycle
vpp  out  DATA_W  vmax - vmin
meas_valid  out  1  one-clock pulse when results update
timeout  out  1  no complete cycle within 2^CNT_W-1 samples

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - period, vmax, vmin, vpp, count = 0.
  - meas_valid=0, timeout=0.
- Sample acceptance: only when sample_valid=1 and en=1. All counting is in accepted samples, not clocks.
- Thresholds: hi_th = MID+HYST, lo_th = MID-HYST. Comparisons are unsigned and inclusive: sample >= hi_th is high, sample <= lo_th is low.
- FSM:
  - IDLE: when en=1, go to ARM_LOW.
  - ARM_LOW: wait for a low sample, then go to ARM_HIGH. This prevents a false edge when the input starts high.
  - ARM_HIGH: on a high sample (opening rising edge):
    - count<=1;
    - vmax<=vmin<=sample (window registers, not outputs);
    - go to MEAS_HIGH.
  - MEAS_HIGH: each sample does count+1 and updates window max/min. On a low sample, go to MEAS_LOW.
  - MEAS_LOW: each non-high sample does count+1 and updates window max/min. On a high sample (closing edge):
    - period<=count;
    - vmax/vmin outputs <= window max/min;
    - vpp<=window max - window min;
    - meas_valid<=1 for exactly one clock;
    - timeout<=0;
    - restart the window with this sample: count<=1, window max=min=sample;
    - go to MEAS_HIGH.
- Window definition: from the rising-edge sample up to, but excluding, the next rising-edge sample. period equals the number of samples in that window.
- Latency: outputs and meas_valid update on the clock edge after the closing-edge sample is accepted.
- Hysteresis: samples strictly between lo_th and hi_th never cause transitions. Noise within ±HYST therefore produces no extra edges.
- Timeout:
  - Trigger: in MEAS_HIGH or MEAS_LOW, a non-edge sample arrives while count == 2^CNT_W-1.
  - Action: timeout<=1 (sticky), go to ARM_LOW. Result outputs hold their values and no meas_valid is issued.
  - count never wraps.
- en deasserted in any state: next state is IDLE, window is discarded, meas_valid=0. period/vmax/vmin/vpp/timeout hold.
- sample_valid=0: all state, counters and windows hold.
- Outputs are registered. No combinational path from inputs to outputs.

Test Plan:
1. Square wave, 64 samples at 12000 then 64 at 4000, repeated; sample_valid=1 -> after second rising edge: meas_valid pulses every 128 samples, period=128, vmax=12000, vmin=4000, vpp=8000.
2. Same wave with sample_valid asserted every other clock -> period=128 (not 256); meas_valid spacing 256 clocks.
3. Noise: ±50 LSB dither of ±1 sample around each crossing, HYST=64 -> exactly one meas_valid per cycle, period unchanged at 128.
4. Timeout with CNT_W=8: after one rising edge, hold input at 12000 -> after 255 further samples timeout=1, outputs hold prior values; then restart the square wave -> new meas_valid and timeout clears.
5. Wave starts high (first sample 12000) -> no result until low then high is seen; first period reported is correct (128).
6. Reset pulse, and separately en=0, mid-window -> all outputs 0 after reset; en=0 holds outputs with no meas_valid; re-enable needs a full re-arm before the next result.
